// File: rtl/addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor: control states and mode encodings.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_bit.sv
// Single combinational full-adder cell shared by every bit position of the serial datapath.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial unsigned add/sub, one bit per clock, start/done handshake.
// Optional signed-overflow flag built only when SIGNED_OVF_EN is defined.
//
// Handshake: start is accepted on a rising edge while in IDLE or DONE and ignored in RUN;
// done pulses for one cycle exactly WIDTH cycles after acceptance, with result/ovf valid
// from then on and held until the next completion or reset.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               s,
  output logic               busy,
  output logic               done,
  output logic [WIDTH:0]     result,
  output logic               ovf,
  output addsub_state_t      dbg_state
);

  addsub_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] acc_q;
  logic             carry_q;
  logic             mode_q;
  logic [WIDTH:0]   result_q;
  logic             fa_s, fa_c;
  logic             accept, last;

  fa_bit u_fa (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign last   = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      mode_q   <= ADD;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Subtraction is A + ~B + 1: B goes in inverted and the +1 rides in the carry.
        a_q     <= a;
        b_q     <= s ? ~b : b;
        carry_q <= s;
        mode_q  <= s;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        carry_q <= fa_c;
        cnt_q   <= cnt_q + 1'b1;
        acc_q   <= {fa_s, acc_q} >> 1;
        if (last) begin
          // Carry out of A + ~B + 1 is the inverse of the borrow.
          result_q <= {(mode_q == SUB) ? ~fa_c : fa_c, fa_s, acc_q};
        end
      end
    end
  end

`ifdef SIGNED_OVF_EN
  logic ovf_q;

  // carry_q still holds the carry into the MSB on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= carry_q ^ fa_c;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=4 and WIDTH=8 against a cycle-level arithmetic model.
module tb_serial_addsub;
  import addsub_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i   [2];
  logic       start_i [2];
  logic       s_i     [2];
  logic [7:0] a_i     [2];
  logic [7:0] b_i     [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       ovf_o   [2];
  logic [8:0] res_o   [2];
  logic [4:0] res4;
  logic [8:0] res8;
  addsub_state_t st0, st1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state
  int         wd      [2] = '{4, 8};
  int         left    [2];
  logic       m_busy  [2];
  logic       m_done  [2];
  logic       m_ovf   [2];
  logic [8:0] m_res   [2];
  logic [9:0] exp_q4[$];
  logic [9:0] exp_q8[$];

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .a(a_i[0][3:0]), .b(b_i[0][3:0]),
    .s(s_i[0]), .busy(busy_o[0]), .done(done_o[0]), .result(res4), .ovf(ovf_o[0]),
    .dbg_state(st0)
  );

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .a(a_i[1]), .b(b_i[1]),
    .s(s_i[1]), .busy(busy_o[1]), .done(done_o[1]), .result(res8), .ovf(ovf_o[1]),
    .dbg_state(st1)
  );

  assign res_o[0] = {4'b0, res4};
  assign res_o[1] = res8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {ovf, result} from plain integer arithmetic on the operands.
  function automatic logic [9:0] model_op(input int w, input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
    int ua, ub, r, sa, sb, sr;
    logic o;
    ua = int'(a) & ((1 << w) - 1);
    ub = int'(b) & ((1 << w) - 1);
    r  = s ? ua - ub : ua + ub;
    r  = r & ((1 << (w + 1)) - 1);
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    sr = s ? sa - sb : sa + sb;
    o  = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
`ifndef SIGNED_OVF_EN
    o = 1'b0;
`endif
    return {o, 9'(r)};
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [9:0] e;
      if (rst_i[d]) begin
        left[d]   = 0;
        m_done[d] = 1'b0;
        m_res[d]  = '0;
        m_ovf[d]  = 1'b0;
        if (d == 0) exp_q4.delete(); else exp_q8.delete();
      end else begin
        m_done[d] = 1'b0;
        if (left[d] > 0) begin
          left[d]--;
          if (left[d] == 0) begin
            e = (d == 0) ? exp_q4.pop_front() : exp_q8.pop_front();
            m_done[d] = 1'b1;
            m_res[d]  = e[8:0];
            m_ovf[d]  = e[9];
          end
        end else if (start_i[d]) begin
          left[d] = wd[d];
          e = model_op(wd[d], a_i[d], b_i[d], s_i[d]);
          if (d == 0) exp_q4.push_back(e); else exp_q8.push_back(e);
        end
      end
      m_busy[d] = (left[d] > 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy%0d", wd[d]), 32'(busy_o[d]), 32'(m_busy[d]));
        chk($sformatf("done%0d", wd[d]), 32'(done_o[d]), 32'(m_done[d]));
        chk($sformatf("result%0d", wd[d]), 32'(res_o[d]), 32'(m_res[d]));
        chk($sformatf("ovf%0d", wd[d]), 32'(ovf_o[d]), 32'(m_ovf[d]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Waits (bounded) for done; returns cycles since acceptance and busy cycles seen.
  task automatic wait_done(input int d, output int k, output int nb);
    k  = 0;
    nb = busy_o[d] ? 1 : 0;
    while (!done_o[d] && k < 40) begin
      step(1);
      k++;
      if (busy_o[d]) nb++;
    end
  endtask

  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [8:0] lit, input logic lit_ovf);
    int k, nb;
    logic exp_ovf;
    start_i[d] = 1'b1;
    a_i[d] = a;
    b_i[d] = b;
    s_i[d] = s;
    step(1);
    start_i[d] = 1'b0;
    a_i[d] = 8'($urandom_range(0, 255));
    b_i[d] = 8'($urandom_range(0, 255));
    s_i[d] = 1'($urandom_range(0, 1));
    wait_done(d, k, nb);
`ifdef SIGNED_OVF_EN
    exp_ovf = lit_ovf;
`else
    exp_ovf = 1'b0;
`endif
    chk($sformatf("latency%0d", wd[d]), 32'(k), 32'(wd[d]));
    chk($sformatf("busy_cycles%0d", wd[d]), 32'(nb), 32'(wd[d]));
    chk($sformatf("lit_result %0h/%0h/%0b", a, b, s), 32'(res_o[d]), 32'(lit));
    chk($sformatf("lit_ovf %0h/%0h/%0b", a, b, s), 32'(ovf_o[d]), 32'(exp_ovf));
  endtask

  initial begin
    int k, nb, ndone;
    for (int d = 0; d < 2; d++) begin
      rst_i[d] = 1'b1; start_i[d] = 1'b0; s_i[d] = 1'b0; a_i[d] = '0; b_i[d] = '0;
    end
    step(2);
    rst_i[0] = 1'b0;
    rst_i[1] = 1'b0;
    chk_en = 1'b1;
    chk("rst_result4", 32'(res_o[0]), 32'h0);
    chk("rst_busy4", 32'(busy_o[0]), 32'h0);
    chk("rst_state4", 32'(st0), 32'(IDLE));
    chk("rst_result8", 32'(res_o[1]), 32'h0);

    // add with carry out
    run_op(0, 8'h7, 8'h9, ADD, 9'h10, 1'b0);
    step(2);
    // subtract without borrow, then back-to-back subtract with borrow
    run_op(0, 8'hF, 8'h7, SUB, 9'h08, 1'b0);
    run_op(0, 8'h7, 8'hF, SUB, 9'h18, 1'b1);
    step(2);

    // start pulsed mid-RUN must be ignored
    start_i[0] = 1'b1; a_i[0] = 8'h2; b_i[0] = 8'h3; s_i[0] = ADD;
    step(1);
    start_i[0] = 1'b0;
    step(1);
    start_i[0] = 1'b1; a_i[0] = 8'h9; b_i[0] = 8'h9; s_i[0] = SUB;
    step(1);
    start_i[0] = 1'b0;
    wait_done(0, k, nb);
    chk("ignored_start_latency", 32'(k), 32'd2);
    chk("ignored_start_result", 32'(res_o[0]), 32'h05);
    ndone = 0;
    repeat (6) begin
      step(1);
      if (done_o[0]) ndone++;
    end
    chk("ignored_start_extra_done", 32'(ndone), 32'd0);

    // reset in the second cycle of RUN
    start_i[0] = 1'b1; a_i[0] = 8'h5; b_i[0] = 8'h3; s_i[0] = ADD;
    step(1);
    start_i[0] = 1'b0;
    step(1);
    rst_i[0] = 1'b1;
    step(1);
    rst_i[0] = 1'b0;
    chk("midrun_rst_busy", 32'(busy_o[0]), 32'h0);
    chk("midrun_rst_done", 32'(done_o[0]), 32'h0);
    chk("midrun_rst_result", 32'(res_o[0]), 32'h0);
    run_op(0, 8'h3, 8'h1, ADD, 9'h04, 1'b0);
    step(1);

    // signed overflow corners and wrap-around
    run_op(0, 8'h7, 8'h1, ADD, 9'h08, 1'b1);
    step(1);
    run_op(0, 8'h8, 8'h1, SUB, 9'h07, 1'b1);
    step(1);
    run_op(0, 8'hF, 8'h1, ADD, 9'h10, 1'b0);
    run_op(0, 8'h0, 8'h1, SUB, 9'h1F, 1'b0);
    step(2);

    // 8-bit instance
    run_op(1, 8'd200, 8'd100, ADD, 9'h12C, 1'b0);
    step(1);
    run_op(1, 8'd255, 8'd1, ADD, 9'h100, 1'b0);
    run_op(1, 8'd10, 8'd20, SUB, 9'h1F6, 1'b0);
    step(3);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
